// File: rtl/dsi_video_pattern_gen_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsi_video_pkg : shared types, colour-bar table and timing helper
// Revision 1.0
// ---------------------------------------------------------------------------
package dsi_video_pkg;

  localparam int PIXEL_BITS = 24;

  typedef enum logic [2:0] {
    MODE_RED     = 3'd0,
    MODE_GREEN   = 3'd1,
    MODE_BLUE    = 3'd2,
    MODE_DIAG    = 3'd3,
    MODE_BARS    = 3'd4,
    MODE_CHECKER = 3'd5,
    MODE_SOLID   = 3'd6,
    MODE_AUTO    = 3'd7
  } mode_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Position inside the colour-bar sequence for the current line.
  typedef struct packed {
    logic [2:0]  bar;
    logic [15:0] cnt;
  } bar_pos_t;

  // Entry 0 is white; the sequence runs towards black at entry 7.
  localparam logic [7:0][PIXEL_BITS-1:0] BAR_TABLE = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic int calc_total(input int sync_len, input int back, input int active,
                                    input int front, input int per_clk);
    return (sync_len + back + active + front) / per_clk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsi_video_pattern_gen_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsi_video_if : video timing and pixel bus towards the DSI TX pixel port
// Revision 1.0
// ---------------------------------------------------------------------------
interface dsi_video_if #(
  parameter int PPC = 2
);
  logic                o_hs;
  logic                o_vs;
  logic                o_de;
  logic [11:0]         o_x;
  logic [11:0]         o_y;
  logic [PPC*24-1:0]   o_data;
  logic                o_frame_start;
  logic [15:0]         o_frame_cnt;
  logic                o_busy;

  modport master (
    output o_hs, o_vs, o_de, o_x, o_y, o_data, o_frame_start, o_frame_cnt, o_busy
  );

  modport slave (
    input o_hs, o_vs, o_de, o_x, o_y, o_data, o_frame_start, o_frame_cnt, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/dsi_video_pattern_gen_pixel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsi_pattern_pixel : one lane of pattern colour from (X, Y, mode, solid, bar)
// Revision 1.0
// ---------------------------------------------------------------------------
module dsi_pattern_pixel
  import dsi_video_pkg::*;
#(
  parameter int CHK_SHIFT = 5
) (
  input  logic [15:0]           x_i,
  input  logic [11:0]           y_i,
  input  logic [2:0]            mode_i,
  input  logic [PIXEL_BITS-1:0] solid_i,
  input  logic [2:0]            bar_i,
  output logic [PIXEL_BITS-1:0] rgb_o
);

  logic [7:0] diag;
  logic       chk;
  logic       unused_hi;

  assign diag      = x_i[7:0] + y_i[7:0];
  assign chk       = x_i[CHK_SHIFT] ^ y_i[CHK_SHIFT];
  assign unused_hi = ^{x_i[15:8], y_i[11:8]};

  always_comb begin
    rgb_o = '0;
    case (mode_e'(mode_i))
      MODE_RED:     rgb_o = {x_i[7:0], 16'h0000};
      MODE_GREEN:   rgb_o = {8'h00, x_i[7:0], 8'h00};
      MODE_BLUE:    rgb_o = {16'h0000, x_i[7:0]};
      MODE_DIAG:    rgb_o = {diag, diag, diag};
      MODE_BARS:    rgb_o = BAR_TABLE[bar_i];
      MODE_CHECKER: rgb_o = chk ? 24'hFFFFFF : 24'h000000;
      MODE_SOLID:   rgb_o = solid_i;
      default:      rgb_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dsi_video_pattern_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsi_video_pattern_gen : video timing generator and PPC-wide test-pattern source
// Revision 1.0
// ---------------------------------------------------------------------------
module dsi_video_pattern_gen
  import dsi_video_pkg::*;
#(
  parameter int PPC        = 2,
  parameter int MAX_HRES   = 1080,
  parameter int MAX_VRES   = 1920,
  parameter int HSP        = 100,
  parameter int HBP        = 100,
  parameter int HFP        = 250,
  parameter int VSP        = 3,
  parameter int VBP        = 5,
  parameter int VFP        = 6,
  parameter int CHK_SHIFT  = 5,
  parameter int AUTO_SHIFT = 7
) (
  input  logic                  i_pclk,
  input  logic                  i_srst,
  input  logic                  i_enable,
  input  logic [2:0]            i_mode,
  input  logic [PIXEL_BITS-1:0] i_solid_rgb,
  dsi_video_if.master           vid
);

  localparam int HT       = calc_total(HSP, HBP, MAX_HRES, HFP, PPC);
  localparam int VT       = calc_total(VSP, VBP, MAX_VRES, VFP, 1);
  localparam int HS_END   = HSP / PPC;
  localparam int HA_START = (HSP + HBP) / PPC;
  localparam int HA_END   = HA_START + MAX_HRES / PPC;
  localparam int VA_START = VSP + VBP;
  localparam int VA_END   = VA_START + MAX_VRES;
  localparam int BAR_W    = MAX_HRES / 8;
  localparam int DW       = PPC * PIXEL_BITS;

  state_e                state_q, state_d;
  logic [15:0]           h_q, h_d;
  logic [15:0]           v_q, v_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [2:0]            mode_q, mode_d;
  logic [PIXEL_BITS-1:0] solid_q, solid_d;
  bar_pos_t              bar_q, bar_d;

  logic                  hs_q, vs_q, de_q, fs_q;
  logic [11:0]           x_q, y_q;
  logic [DW-1:0]         data_q;

  logic                  run;
  logic                  h_last;
  logic                  v_last;
  logic                  frame_first;
  logic                  de;
  logic [11:0]           act_x;
  logic [11:0]           act_y;
  logic [2:0]            auto_mode;
  logic [DW-1:0]         pix_data;

  // Walks the bar position forward by 'step' pixels; bars may be narrower
  // than one pixel group, so several bar boundaries can be crossed at once.
  function automatic bar_pos_t bar_advance(input bar_pos_t pos, input int step);
    bar_pos_t r;
    r.bar = pos.bar;
    r.cnt = pos.cnt + 16'(step);
    for (int k = 0; k < PPC; k++) begin
      if (r.cnt >= 16'(BAR_W)) begin
        r.cnt = r.cnt - 16'(BAR_W);
        r.bar = r.bar + 3'd1;
      end
    end
    return r;
  endfunction

  assign run         = (state_q == ST_RUN);
  assign h_last      = (h_q == 16'(HT - 1));
  assign v_last      = (v_q == 16'(VT - 1));
  assign frame_first = run && (h_q == 16'd0) && (v_q == 16'd0);
  assign de          = run && (h_q >= 16'(HA_START)) && (h_q < 16'(HA_END)) &&
                       (v_q >= 16'(VA_START)) && (v_q < 16'(VA_END));
  assign act_x       = 12'(h_q - 16'(HA_START));
  assign act_y       = 12'(v_q - 16'(VA_START));
  assign auto_mode   = {1'b0, frame_cnt_q[AUTO_SHIFT+1 -: 2]};

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;
    mode_d      = mode_q;
    solid_d     = solid_q;
    bar_d       = bar_q;
    unique case (state_q)
      ST_IDLE: begin
        h_d   = '0;
        v_d   = '0;
        bar_d = '0;
        if (i_enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (frame_first) begin
          mode_d  = (mode_e'(i_mode) == MODE_AUTO) ? auto_mode : i_mode;
          solid_d = i_solid_rgb;
        end
        bar_d = de ? bar_advance(bar_q, PPC) : '0;
        if (h_last) begin
          h_d = '0;
          if (v_last) begin
            v_d         = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (!i_enable) begin
              state_d = ST_IDLE;
            end
          end else begin
            v_d = v_q + 16'd1;
          end
        end else begin
          h_d = h_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_pclk) begin
    if (i_srst) begin
      state_q     <= ST_IDLE;
      h_q         <= '0;
      v_q         <= '0;
      frame_cnt_q <= '0;
      mode_q      <= '0;
      solid_q     <= '0;
      bar_q       <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
      solid_q     <= solid_d;
      bar_q       <= bar_d;
    end
  end

  for (genvar p = 0; p < PPC; p++) begin : g_lane
    bar_pos_t              lane_pos;
    logic [15:0]           lane_x;
    logic [PIXEL_BITS-1:0] lane_rgb;
    logic                  unused_lane;

    assign lane_pos    = bar_advance(bar_q, p);
    assign lane_x      = {4'd0, act_x} * 16'(PPC) + 16'(p);
    assign unused_lane = ^lane_pos.cnt;

    dsi_pattern_pixel #(
      .CHK_SHIFT (CHK_SHIFT)
    ) u_pixel (
      .x_i     (lane_x),
      .y_i     (act_y),
      .mode_i  (mode_q),
      .solid_i (solid_q),
      .bar_i   (lane_pos.bar),
      .rgb_o   (lane_rgb)
    );

    assign pix_data[p*PIXEL_BITS +: PIXEL_BITS] = lane_rgb;
  end

  // Outputs trail the counters by one clock; everything is gated by RUN.
  always_ff @(posedge i_pclk) begin
    if (i_srst) begin
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      data_q <= '0;
    end else begin
      hs_q   <= run && (h_q < 16'(HS_END));
      vs_q   <= run && (v_q < 16'(VSP));
      de_q   <= de;
      fs_q   <= frame_first;
      x_q    <= de ? act_x : '0;
      y_q    <= de ? act_y : '0;
      data_q <= de ? pix_data : '0;
    end
  end

  assign vid.o_hs          = hs_q;
  assign vid.o_vs          = vs_q;
  assign vid.o_de          = de_q;
  assign vid.o_x           = x_q;
  assign vid.o_y           = y_q;
  assign vid.o_data        = data_q;
  assign vid.o_frame_start = fs_q;
  assign vid.o_frame_cnt   = frame_cnt_q;
  assign vid.o_busy        = run;

endmodule
`default_nettype wire

// File: tb/tb_dsi_video_pattern_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dsi_video_pattern_gen : small-config bench with a frame-position model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_dsi_video_pattern_gen;

  localparam int PPC = 2, MAX_HRES = 8, MAX_VRES = 4;
  localparam int HSP = 2, HBP = 2, HFP = 4, VSP = 1, VBP = 1, VFP = 1;
  localparam int CHK_SHIFT = 1, AUTO_SHIFT = 1;
  localparam int HT = (HSP + HBP + MAX_HRES + HFP) / PPC;
  localparam int VT = VSP + VBP + MAX_VRES + VFP;
  localparam int FRAME = HT * VT;

  logic        clk, rst, en;
  logic [2:0]  mode;
  logic [23:0] solid;
  bit          force_req;

  dsi_video_if #(.PPC(PPC)) vif ();

  dsi_video_pattern_gen #(
    .PPC(PPC), .MAX_HRES(MAX_HRES), .MAX_VRES(MAX_VRES),
    .HSP(HSP), .HBP(HBP), .HFP(HFP), .VSP(VSP), .VBP(VBP), .VFP(VFP),
    .CHK_SHIFT(CHK_SHIFT), .AUTO_SHIFT(AUTO_SHIFT)
  ) dut (
    .i_pclk      (clk),
    .i_srst      (rst),
    .i_enable    (en),
    .i_mode      (mode),
    .i_solid_rgb (solid),
    .vid         (vif)
  );

  always #5 clk = ~clk;

  // Reference colour of one pixel from the pattern rules.
  function automatic logic [23:0] ref_pixel(input int m, input int xx, input int yy,
                                            input logic [23:0] sol);
    logic [7:0] s;
    int b;
    case (m)
      0: return {8'(xx % 256), 16'h0000};
      1: return {8'h00, 8'(xx % 256), 8'h00};
      2: return {16'h0000, 8'(xx % 256)};
      3: begin s = 8'((xx + yy) % 256); return {s, s, s}; end
      4: begin
        b = xx / (MAX_HRES / 8);
        case (b)
          0: return 24'hFFFFFF;  // white
          1: return 24'hFFFF00;  // yellow
          2: return 24'h00FFFF;  // cyan
          3: return 24'h00FF00;  // green
          4: return 24'hFF00FF;  // magenta
          5: return 24'hFF0000;  // red
          6: return 24'h0000FF;  // blue
          default: return 24'h000000;
        endcase
      end
      5: return ((((xx >> CHK_SHIFT) ^ (yy >> CHK_SHIFT)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      6: return sol;
      default: return 24'h000000;
    endcase
  endfunction

  // Model: frame position index plus latched mode and frame count.
  bit          m_run;
  int          m_pos;
  logic [15:0] m_fc;
  int          m_mode;
  logic [23:0] m_solid;
  logic        e_hs, e_vs, e_de, e_fs, e_busy;
  int          e_x, e_y, e_mode;
  logic [47:0] e_data;
  logic [15:0] e_fc;

  always @(posedge clk) begin
    int h, v, gx, gy;
    if (rst) begin
      m_run = 0; m_pos = 0; m_fc = 0; m_mode = 0; m_solid = 0;
      {e_hs, e_vs, e_de, e_fs} = '0; e_x = 0; e_y = 0; e_data = '0; e_mode = 0;
    end else begin
      if (force_req) m_fc = 16'hFFFF;
      {e_hs, e_vs, e_de, e_fs} = '0; e_x = 0; e_y = 0; e_data = '0;
      if (!m_run) begin
        if (en) begin m_run = 1; m_pos = 0; end
      end else begin
        h = m_pos % HT;
        v = m_pos / HT;
        if (m_pos == 0) begin
          m_mode  = (mode == 3'd7) ? int'((m_fc >> AUTO_SHIFT) % 4) : int'(mode);
          m_solid = solid;
        end
        e_hs = (h < HSP / PPC);
        e_vs = (v < VSP);
        e_fs = (m_pos == 0);
        gx = h - (HSP + HBP) / PPC;
        gy = v - (VSP + VBP);
        if (gx >= 0 && gx < MAX_HRES / PPC && gy >= 0 && gy < MAX_VRES) begin
          e_de = 1; e_x = gx; e_y = gy; e_mode = m_mode;
          for (int p = 0; p < PPC; p++)
            e_data[p*24 +: 24] = ref_pixel(m_mode, gx * PPC + p, gy, m_solid);
        end
        if (m_pos == FRAME - 1) begin
          m_fc = m_fc + 16'd1;
          m_pos = 0;
          if (!en) m_run = 0;
        end else begin
          m_pos = m_pos + 1;
        end
      end
    end
    e_fc   = m_fc;
    e_busy = m_run;
  end

  int vectors = 0, miscompares = 0, cyc = 0;
  bit armed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  always begin
    bit prev_busy, run_cont, first_pend;
    int rise_cyc, last_fs;
    logic [15:0] prev_fc;
    @(posedge clk);
    if (rst) armed = 1;
    #1;
    if (armed) begin
      cyc++;
      chk("sync{hs,vs,de,fs,busy}", {vif.o_hs, vif.o_vs, vif.o_de, vif.o_frame_start, vif.o_busy},
          {e_hs, e_vs, e_de, e_fs, e_busy});
      chk("pos{x,y}", {vif.o_x, vif.o_y}, {12'(e_x), 12'(e_y)});
      chk("data", vif.o_data, e_data);
      chk("frame_cnt", vif.o_frame_cnt, e_fc);
      // Hand-computed values pinning the model.
      if (e_de && e_mode == 0 && e_x == 0) chk("pin_ramp_x0", vif.o_data, 48'h010000_000000);
      if (e_de && e_mode == 0 && e_x == 3) chk("pin_ramp_x3", vif.o_data, 48'h070000_060000);
      if (e_de && e_mode == 3 && e_x == 0 && e_y == 1) chk("pin_diag_y1", vif.o_data, 48'h020202_010101);
      if (e_de && e_mode == 4 && e_x == 0) chk("pin_bars_x0", vif.o_data, 48'hFFFF00_FFFFFF);
      if (e_de && e_mode == 4 && e_x == 3) chk("pin_bars_x3", vif.o_data, 48'h000000_0000FF);
      if (e_de && e_mode == 6 && m_solid == 24'h123456) chk("pin_solid", vif.o_data, 48'h123456_123456);
      if (prev_fc == 16'hFFFF && e_fc != 16'hFFFF) chk("pin_fc_wrap", vif.o_frame_cnt, 16'h0000);
      if (!e_busy) run_cont = 0;
      if (e_busy && !prev_busy) begin rise_cyc = cyc; first_pend = 1; end
      if (vif.o_frame_start) begin
        if (first_pend) chk("pin_fs_latency", 64'(cyc - rise_cyc), 64'd1);
        if (run_cont) chk("pin_fs_period", 64'(cyc - last_fs), 64'd56);
        first_pend = 0; run_cont = 1; last_fs = cyc;
      end
      prev_busy = e_busy;
      prev_fc = e_fc;
    end
  end

  initial begin
    clk = 0; rst = 1; en = 0; mode = 3'd0; solid = 24'h0; force_req = 0;
    repeat (3) @(negedge clk);
    rst = 0; en = 1; mode = 3'd0;
    repeat (FRAME + 20) @(negedge clk);
    mode = 3'd6; solid = 24'h123456;
    repeat (FRAME * 2) @(negedge clk);
    mode = 3'd3; repeat (FRAME) @(negedge clk);
    mode = 3'd4; repeat (FRAME) @(negedge clk);
    mode = 3'd5; repeat (FRAME) @(negedge clk);
    en = 0; repeat (FRAME + 20) @(negedge clk);
    en = 1; mode = 3'd0; repeat (30) @(negedge clk);
    rst = 1; @(negedge clk); rst = 0;
    repeat (12) @(negedge clk);
    rst = 1; @(negedge clk); rst = 0;
    mode = 3'd7; en = 1;
    repeat (FRAME * 9 + 10) @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    force_req = 1;
    @(negedge clk);
    release dut.frame_cnt_q;
    force_req = 0;
    repeat (FRAME * 2) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      mode  = 3'($urandom_range(0, 7));
      solid = 24'($urandom);
      en    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) begin
        rst = 1; @(negedge clk); rst = 0;
      end
      repeat ($urandom_range(1, 90)) @(negedge clk);
    end
    en = 1;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
